// File: rtl/drm_sdp_fifo_ctrl.sv
// FIFO controller around an external simple dual-port RAM with a 1-cycle read.
// A two-entry output buffer absorbs the read latency so both sides stream at full rate.
module drm_sdp_fifo_ctrl #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 8,
    parameter int BE_WIDTH   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  full,
    output logic                  empty,
    output logic                  ram_wr_en,
    output logic [ADDR_WIDTH-1:0] ram_wr_addr,
    output logic [DATA_WIDTH-1:0] ram_wr_data,
    output logic [BE_WIDTH-1:0]   ram_wr_byte_en,
    output logic [ADDR_WIDTH-1:0] ram_rd_addr,
    input  logic [DATA_WIDTH-1:0] ram_rd_data
);

    localparam int PW = ADDR_WIDTH + 1;
    localparam logic [PW-1:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

    logic [PW-1:0]         wptr_q, wptr_d;
    logic [PW-1:0]         rptr_q, rptr_d;
    logic [PW-1:0]         ram_cnt;
    logic                  inflight_q, inflight_d;
    logic [1:0]            obuf_cnt_q, obuf_cnt_d;
    logic [DATA_WIDTH-1:0] obuf0_q, obuf0_d;
    logic [DATA_WIDTH-1:0] obuf1_q, obuf1_d;
    logic                  clr, accept, fetch, pop, push;
    logic [1:0]            pop2, push2, after_pop;
    logic [2:0]            occ;

    always_comb begin
        clr       = rst | flush;
        ram_cnt   = wptr_q - rptr_q;
        full      = (ram_cnt == DEPTH);
        in_ready  = !full && !clr;
        accept    = in_valid && in_ready;
        out_valid = (obuf_cnt_q != 2'd0);
        pop       = out_valid && out_ready;
        push      = inflight_q;
        pop2      = {1'b0, pop};
        push2     = {1'b0, push};
        after_pop = obuf_cnt_q - pop2;
        // Slots already claimed after this cycle's pop, counting the word in flight.
        occ       = {1'b0, obuf_cnt_q} + {2'b0, inflight_q} - {2'b0, pop};
        fetch     = (ram_cnt != '0) && (occ < 3'd2);

        wptr_d     = accept ? wptr_q + PW'(1) : wptr_q;
        rptr_d     = fetch ? rptr_q + PW'(1) : rptr_q;
        inflight_d = fetch;
        obuf_cnt_d = after_pop + push2;

        obuf0_d = obuf0_q;
        obuf1_d = obuf1_q;
        if (pop) begin
            obuf0_d = obuf1_q;
        end
        if (push) begin
            if (after_pop == 2'd0) begin
                obuf0_d = ram_rd_data;
            end else begin
                obuf1_d = ram_rd_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            inflight_q <= 1'b0;
            obuf_cnt_q <= 2'd0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            inflight_q <= inflight_d;
            obuf_cnt_q <= obuf_cnt_d;
        end
        obuf0_q <= obuf0_d;
        obuf1_q <= obuf1_d;
    end

    assign out_data       = obuf0_q;
    assign count          = ram_cnt + PW'(inflight_q) + PW'(obuf_cnt_q);
    assign empty          = (count == '0);
    assign ram_wr_en      = accept;
    assign ram_wr_addr    = wptr_q[ADDR_WIDTH-1:0];
    assign ram_wr_data    = in_data;
    assign ram_wr_byte_en = '1;
    assign ram_rd_addr    = rptr_q[ADDR_WIDTH-1:0];

endmodule

// File: tb/tb_drm_sdp_fifo_ctrl.sv
// Directed bench for drm_sdp_fifo_ctrl with a behavioural RAM and a
// scoreboard queue filled on accept and drained on output handshake.
module tb_drm_sdp_fifo_ctrl;

    logic        clk = 1'b0;
    logic        rst, flush;
    logic [7:0]  in_data;
    logic        in_valid, in_ready;
    logic [7:0]  out_data;
    logic        out_valid, out_ready;
    logic [10:0] count;
    logic        full, empty;
    logic        ram_wr_en;
    logic [9:0]  ram_wr_addr;
    logic [7:0]  ram_wr_data;
    logic [0:0]  ram_wr_byte_en;
    logic [9:0]  ram_rd_addr;
    logic [7:0]  ram_rd_data;

    logic [7:0] mem [0:1023];
    logic [7:0] exp_q [$];
    int total = 0;
    int bad = 0;
    int wcount = 0;
    int pops = 0;
    bit gap_mode = 0;
    bit first_seen = 0;
    bit hold_q = 0;
    logic [7:0] hold_d;

    always #5 clk = ~clk;

    drm_sdp_fifo_ctrl dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .count(count), .full(full), .empty(empty),
        .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr),
        .ram_wr_data(ram_wr_data), .ram_wr_byte_en(ram_wr_byte_en),
        .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data)
    );

    always @(posedge clk) begin
        if (ram_wr_en) mem[ram_wr_addr] <= ram_wr_data;
        ram_rd_data <= mem[ram_rd_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        logic [7:0] e;
        @(negedge clk);
        if (in_valid && in_ready) begin
            exp_q.push_back(in_data);
            wcount++;
        end
        if (gap_mode && first_seen && exp_q.size() > 0)
            chk("gap", 32'(out_valid), 32'd1);
        if (hold_q && out_valid)
            chk("hold", 32'(out_data), 32'(hold_d));
        hold_q = out_valid && !out_ready;
        hold_d = out_data;
        if (out_valid && out_ready) begin
            pops++;
            if (exp_q.size() == 0) begin
                chk("sb_empty", 32'(exp_q.size()), 32'd1);
            end else begin
                e = exp_q.pop_front();
                chk("data", 32'(out_data), 32'(e));
            end
            if (gap_mode) first_seen = 1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag);
        out_ready = 1'b1;
        in_valid  = 1'b0;
        for (int n = 0; n < 3000 && exp_q.size() != 0; n++) tick();
        chk(tag, 32'(exp_q.size()), 32'd0);
        chk({tag, "_empty"}, 32'(empty), 32'd1);
    endtask

    initial begin
        int acc;
        int sent;
        logic [7:0] d;

        rst = 1'b1; flush = 1'b0;
        in_valid = 1'b1; in_data = 8'h99; out_ready = 1'b0;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_wr_en", 32'(ram_wr_en), 32'd0);
        tick(); tick();
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        rst = 1'b0; in_valid = 1'b0;
        #1;
        chk("post_rst_ready", 32'(in_ready), 32'd1);

        // single word latency
        in_valid = 1'b1; in_data = 8'hA5; out_ready = 1'b1;
        #1;
        chk("a5_wr_en", 32'(ram_wr_en), 32'd1);
        chk("a5_wr_addr", 32'(ram_wr_addr), 32'd0);
        chk("a5_byte_en", 32'(ram_wr_byte_en), 32'd1);
        tick();
        in_valid = 1'b0;
        tick();
        chk("a5_not_yet", 32'(out_valid), 32'd0);
        tick();
        chk("a5_valid", 32'(out_valid), 32'd1);
        chk("a5_data", 32'(out_data), 32'hA5);
        tick();
        chk("a5_pops", 32'(pops), 32'd1);
        chk("a5_empty", 32'(empty), 32'd1);

        // streaming 1024 words counting down
        gap_mode = 1; first_seen = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 1024; i++) begin
            d = 8'hFF - 8'(i);
            in_valid = 1'b1; in_data = d;
            #1;
            chk("stream_ready", 32'(in_ready), 32'd1);
            tick();
        end
        drain("stream_drain");
        gap_mode = 0;

        // fill with out_ready low
        out_ready = 1'b0; acc = 0;
        for (int i = 0; i < 1100; i++) begin
            in_valid = 1'b1; in_data = 8'(i);
            #1;
            if (!in_ready) break;
            acc++;
            tick();
        end
        chk("fill_accepts", 32'(acc), 32'd1026);
        chk("fill_full", 32'(full), 32'd1);
        chk("fill_count", 32'(count), 32'd1026);
        chk("fill_no_write", 32'(ram_wr_en), 32'd0);

        // one pop at full frees a slot
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        #1;
        chk("full_release", 32'(in_ready), 32'd1);
        in_valid = 1'b1; in_data = 8'h77;
        #1;
        chk("wrap_addr", 32'(ram_wr_addr), 32'(wcount % 1024));
        chk("wrap_wr_en", 32'(ram_wr_en), 32'd1);
        tick();
        chk("refull", 32'(full), 32'd1);
        drain("full_drain");

        // backpressure toggling every 3 cycles
        sent = 0;
        for (int c = 0; c < 400; c++) begin
            out_ready = ((c / 3) % 2) == 0;
            in_valid = (sent < 20);
            in_data = 8'h40 + 8'(sent);
            #1;
            if (in_valid && in_ready) sent++;
            tick();
            if (sent == 20 && exp_q.size() == 0) break;
        end
        chk("bp_sent", 32'(sent), 32'd20);
        chk("bp_done", 32'(exp_q.size()), 32'd0);

        // flush with words held and a read in flight
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_data = 8'h10 + 8'(i);
            tick();
        end
        in_data = 8'h15; out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("pre_flush_count", 32'(count), 32'd5);
        flush = 1'b1; in_valid = 1'b1; in_data = 8'hEE;
        #1;
        chk("flush_ready", 32'(in_ready), 32'd0);
        chk("flush_wr_en", 32'(ram_wr_en), 32'd0);
        tick();
        exp_q.delete();
        flush = 1'b0; in_valid = 1'b0;
        #1;
        chk("flush_count", 32'(count), 32'd0);
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        chk("flush_in_ready", 32'(in_ready), 32'd1);
        tick(); tick();
        chk("flush_no_stale", 32'(out_valid), 32'd0);
        in_valid = 1'b1; in_data = 8'h3C;
        tick();
        in_valid = 1'b0;
        tick(); tick();
        chk("post_flush_first", 32'(out_data), 32'h3C);
        drain("post_flush_drain");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
